// File: rtl/btn_pkg.sv
// Shared types and default parameters for the button debounce/scan controller.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    P_CHK = 2'd1,
    HELD  = 2'd2,
    R_CHK = 2'd3
  } btn_state_t;

  localparam int unsigned NUM_BTN_DEF      = 4;
  localparam int unsigned TICK_DIV_DEF     = 50000;
  localparam int unsigned STABLE_TICKS_DEF = 10;
  localparam int unsigned REPEAT_DELAY_DEF = 300;
  localparam int unsigned REPEAT_RATE_DEF  = 40;

endpackage

// File: rtl/btn_channel.sv
// One button channel: debounce FSM with stable and auto-repeat counters,
// advancing only on the shared sample tick.
//
// state | meaning
// IDLE  | released, waiting for a pressed sample
// P_CHK | counting consecutive pressed samples
// HELD  | debounced pressed, auto-repeat running
// R_CHK | counting consecutive released samples, repeat frozen
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEF,
  parameter int unsigned REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_RATE  = REPEAT_RATE_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic sync_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic act_o
);

  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  localparam int REP_RELOAD_I = (REPEAT_RATE >= REPEAT_DELAY) ? 0 : int'(REPEAT_DELAY - REPEAT_RATE);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_TICKS - 1);
  localparam logic [RW-1:0] REP_TOP    = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] REP_RELOAD = RW'(REP_RELOAD_I);
  // With a single required sample the check states are passed through on entry.
  localparam bit ONE_SHOT = (STABLE_TICKS == 1);

  btn_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rep_q, rep_d, rep_inc;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          act_q, act_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rep_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      act_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rep_q     <= rep_d;
      press_q   <= press_d;
      release_q <= release_d;
      act_q     <= act_d;
    end
  end

  assign rep_inc = rep_q + RW'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rep_d     = rep_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    act_d     = 1'b0;
    if (tick_i) begin
      case (state_q)
        IDLE: begin
          if (sync_i) begin
            if (ONE_SHOT) begin
              state_d = HELD;
              cnt_d   = '0;
              rep_d   = '0;
              press_d = 1'b1;
              act_d   = 1'b1;
            end else begin
              state_d = P_CHK;
              cnt_d   = CNT_ONE;
            end
          end
        end
        P_CHK: begin
          if (!sync_i) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = HELD;
            cnt_d   = '0;
            rep_d   = '0;
            press_d = 1'b1;
            act_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        HELD: begin
          if (!sync_i) begin
            if (ONE_SHOT) begin
              state_d   = IDLE;
              cnt_d     = '0;
              rep_d     = '0;
              release_d = 1'b1;
            end else begin
              state_d = R_CHK;
              cnt_d   = CNT_ONE;
            end
          end else if (rep_inc == REP_TOP) begin
            rep_d = REP_RELOAD;
            act_d = 1'b1;
          end else begin
            rep_d = rep_inc;
          end
        end
        R_CHK: begin
          if (sync_i) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = IDLE;
            cnt_d     = '0;
            rep_d     = '0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          rep_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    level_o   = (state_q == HELD) || (state_q == R_CHK);
    press_o   = press_q;
    release_o = release_q;
    act_o     = act_q;
  end

endmodule

// File: rtl/button_scan_ctrl.sv
// Debounce/auto-repeat controller for the player buttons: input synchronizer,
// one shared sample prescaler and one btn_channel per button.
module button_scan_ctrl
  import btn_pkg::*;
#(
  parameter int unsigned NUM_BTN      = NUM_BTN_DEF,
  parameter int unsigned TICK_DIV     = TICK_DIV_DEF,
  parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEF,
  parameter int unsigned REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_RATE  = REPEAT_RATE_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_BTN-1:0] raw_i,
  output logic [NUM_BTN-1:0] level_o,
  output logic [NUM_BTN-1:0] press_o,
  output logic [NUM_BTN-1:0] release_o,
  output logic [NUM_BTN-1:0] act_o,
  output logic               tick_o
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRES_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]      pres_q;
  logic               tick_q;
  logic [NUM_BTN-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pres_q  <= '0;
      tick_q  <= 1'b0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      pres_q  <= (pres_q == PRES_LAST) ? '0 : pres_q + PW'(1);
      tick_q  <= (pres_q == PRES_LAST);
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  assign tick_o = tick_q;

  for (genvar g = 0; g < int'(NUM_BTN); g++) begin : g_ch
    btn_channel #(
      .STABLE_TICKS(STABLE_TICKS),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
    ) u_ch (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .tick_i   (tick_q),
      .sync_i   (sync2_q[g]),
      .level_o  (level_o[g]),
      .press_o  (press_o[g]),
      .release_o(release_o[g]),
      .act_o    (act_o[g])
    );
  end

endmodule

// File: tb/tb_button_scan_ctrl.sv
// Directed bench for button_scan_ctrl with a per-cycle behavioural reference
// and a few literal checks on pulse counts and latencies.
module tb_button_scan_ctrl;

  localparam int NB = 4;
  localparam int TD = 4;
  localparam int ST = 3;
  localparam int RD = 5;
  localparam int RR = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] raw;
  logic [NB-1:0] level, press, rel, act;
  logic          tick;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_scan_ctrl #(
    .NUM_BTN(NB), .TICK_DIV(TD), .STABLE_TICKS(ST),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .raw_i    (raw),
    .level_o  (level),
    .press_o  (press),
    .release_o(rel),
    .act_o    (act),
    .tick_o   (tick)
  );

  // Reference: level flips after ST consecutive disagreeing samples; repeat
  // counts consecutive pressed samples after the press.
  int            pc;
  logic          e_tick;
  logic [NB-1:0] sm1, sm2;
  logic [NB-1:0] e_level, e_press, e_rel, e_act;
  int            run [NB];
  int            held[NB];
  bit            prev_s[NB];
  bit            s_m;

  always @(posedge clk) begin
    if (rst) begin
      pc = 0; e_tick = 1'b0; sm1 = '0; sm2 = '0;
      e_level = '0; e_press = '0; e_rel = '0; e_act = '0;
      for (int ch = 0; ch < NB; ch++) begin
        run[ch] = 0; held[ch] = 0; prev_s[ch] = 1'b0;
      end
    end else begin
      e_press = '0; e_rel = '0; e_act = '0;
      if (e_tick) begin
        for (int ch = 0; ch < NB; ch++) begin
          s_m = sm2[ch];
          if (!e_level[ch]) begin
            run[ch] = s_m ? run[ch] + 1 : 0;
            if (run[ch] == ST) begin
              e_level[ch] = 1'b1; e_press[ch] = 1'b1; e_act[ch] = 1'b1;
              held[ch] = 0; run[ch] = 0;
            end
          end else if (!s_m) begin
            run[ch] = run[ch] + 1;
            if (run[ch] == ST) begin
              e_level[ch] = 1'b0; e_rel[ch] = 1'b1; run[ch] = 0;
            end
          end else begin
            run[ch] = 0;
            if (prev_s[ch]) begin
              held[ch] = held[ch] + 1;
              if (held[ch] >= RD && (held[ch] - RD) % RR == 0) e_act[ch] = 1'b1;
            end
          end
          prev_s[ch] = s_m;
        end
      end
      e_tick = (pc == TD - 1);
      pc = (pc + 1) % TD;
      sm2 = sm1;
      sm1 = raw;
    end
  end

  int tot_press[NB] = '{default: 0};
  int tot_rel  [NB] = '{default: 0};
  int tot_act  [NB] = '{default: 0};
  int all_press = 0;
  int all_rel   = 0;

  task automatic step();
    logic [16:0] got, exp;
    @(negedge clk);
    got = {tick, level, press, rel, act};
    exp = {e_tick, e_level, e_press, e_rel, e_act};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL model_cmp t=%0t got=%h exp=%h (tick,level,press,release,act)", $time, got, exp);
    end
    for (int ch = 0; ch < NB; ch++) begin
      tot_press[ch] += int'(press[ch]);
      tot_rel[ch]   += int'(rel[ch]);
      tot_act[ch]   += int'(act[ch]);
    end
    if (press == 4'hF) all_press++;
    if (rel == 4'hF) all_rel++;
  endtask

  task automatic wait_ticks(input int n);
    repeat (n * TD) step();
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic wait_press(input int ch, input int budget, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    for (int i = 1; i <= budget && !seen; i++) begin
      step();
      if (press[ch]) begin
        seen = 1'b1;
        n = i;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL press_timeout ch=%0d got=none exp=press within %0d clk", ch, budget);
    end
  endtask

  int p0, a0, r0, n;
  bit found;

  initial begin
    rst = 1'b1;
    raw = 4'hF;
    repeat (3) begin
      step();
      check("reset_outputs", int'({level, press, rel, act, tick}), 0);
    end
    rst = 1'b0;
    raw = 4'h0;
    n = 0; found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (tick && !found) begin
        n = i; found = 1'b1;
      end
    end
    check("first_tick_clk", n, 4);

    // clean press/release on btn0
    p0 = tot_press[0]; a0 = tot_act[0]; r0 = tot_rel[0];
    raw[0] = 1'b1;
    wait_ticks(8);
    check("btn0_press_cnt", tot_press[0] - p0, 1);
    check("btn0_act_cnt", tot_act[0] - a0, 1);
    check("btn0_level_hi", int'(level[0]), 1);
    raw[0] = 1'b0;
    wait_ticks(8);
    check("btn0_release_cnt", tot_rel[0] - r0, 1);
    check("btn0_level_lo", int'(level[0]), 0);

    // glitch rejection on btn1
    p0 = tot_press[1]; a0 = tot_act[1];
    raw[1] = 1'b1;
    repeat (2 * TD) step();
    raw[1] = 1'b0;
    wait_ticks(6);
    check("btn1_glitch_press", tot_press[1] - p0, 0);
    check("btn1_glitch_act", tot_act[1] - a0, 0);
    check("btn1_glitch_level", int'(level[1]), 0);
    raw[1] = 1'b1;
    wait_ticks(8);
    check("btn1_held_level", int'(level[1]), 1);
    r0 = tot_rel[1];
    raw[1] = 1'b0;
    repeat (2 * TD) step();
    raw[1] = 1'b1;
    wait_ticks(6);
    check("btn1_dropout_release", tot_rel[1] - r0, 0);
    check("btn1_dropout_level", int'(level[1]), 1);
    raw[1] = 1'b0;
    wait_ticks(8);

    // auto-repeat on btn2: press + repeats at 5,7,9,11,13,15 held ticks
    p0 = tot_press[2]; a0 = tot_act[2]; r0 = tot_rel[2];
    raw[2] = 1'b1;
    wait_press(2, 40, n);
    wait_ticks(15);
    raw[2] = 1'b0;
    wait_ticks(8);
    check("btn2_act_cnt", tot_act[2] - a0, 7);
    check("btn2_press_cnt", tot_press[2] - p0, 1);
    check("btn2_release_cnt", tot_rel[2] - r0, 1);

    // simultaneous channels
    p0 = all_press; r0 = all_rel;
    raw = 4'hF;
    wait_ticks(6);
    check("all_press_cycles", all_press - p0, 1);
    check("all_level_hi", int'(level), 15);
    raw = 4'h0;
    wait_ticks(6);
    check("all_release_cycles", all_rel - r0, 1);
    check("all_level_lo", int'(level), 0);

    // reset while btn3 is held
    raw[3] = 1'b1;
    wait_ticks(6);
    check("btn3_held_level", int'(level[3]), 1);
    r0 = tot_rel[3];
    rst = 1'b1;
    step();
    check("btn3_rst_level", int'(level[3]), 0);
    step();
    rst = 1'b0;
    wait_press(3, 40, n);
    check("btn3_repress_clk", n, 13);
    check("btn3_no_release", tot_rel[3] - r0, 0);
    raw = 4'h0;
    wait_ticks(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
